// File: rtl/cla_nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead nibble per cycle,
// registered carry between nibbles, valid/ready on both sides.

// 4-bit flattened lookahead: every carry is a two-level g/p product term.
module cla_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);
  logic [3:0] g, p;
  logic       c1, c2;

  // generate/propagate, lookahead carries and nibble sum
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
  end
endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [NIBBLES-1:0][3:0]   a_q, b_q, sum_q;
  logic [IDX_W-1:0]          idx;
  logic                      creg;
  logic                      last;
  logic [3:0]                nib_s;
  logic                      nib_c3, nib_c4;

  assign last = (idx == IDX_W'(NIBBLES - 1));

  cla_nibble u_cla (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (creg),
    .s  (nib_s),
    .c3 (nib_c3),
    .c4 (nib_c4)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, per-nibble sum/carry update, final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      idx   <= '0;
      creg  <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          creg <= cin;
          idx  <= '0;
        end
        RUN: begin
          sum_q[idx] <= nib_s;
          creg       <= nib_c4;
          idx        <= idx + IDX_W'(1);
          if (last) begin
            cout <= nib_c4;
            ovf  <= nib_c3 ^ nib_c4;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = sum_q;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench: drivers push expected results, a negedge monitor pops
// and compares on every accepted output transfer.
module tb_cla_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf, busy;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cla_nibble_serial_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: compare every transfer that will complete at the next edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: sum=%h cout=%b ovf=%b", sum, cout, ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
          errors++;
          $display("FAIL result: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  // present operands until accepted; optionally hold in_valid with junk during RUN
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input bit junk);
    int n;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 50) begin
        errors++; checks++;
        $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    if (junk) begin
      repeat (6) begin
        a = $urandom; b = $urandom; cin = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                    input logic [31:0] es, input logic ec, input logic eo, input bit junk);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo;
    sb.push_back(e);
    send(ta, tb_, tc, junk);
  endtask

  // independent reference: 33-bit add, overflow from operand/result signs
  task automatic rand_op(input bit junk);
    logic [31:0] ra, rb, rs;
    logic        rc, co;
    ra = $urandom; rb = $urandom; rc = 1'($urandom);
    {co, rs} = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
    op(ra, rb, rc, rs, co, (ra[31] == rb[31]) && (rs[31] != ra[31]), junk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // test 1 with latency measurement
    op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("latency", 32'(cyc), 32'd8);
    drain();

    // directed vectors
    op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    op(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
    op(32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 1'b0, 1'b0, 1'b0);
    drain();

    // back-pressure in DONE
    out_ready = 1'b0;
    op(32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", sum, 32'h00000010);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // reset abort while processing nibble 3
    send(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);
    drain();

    // in_valid held with changing operands during RUN
    op(32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b1);
    op(32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    drain();

    // random operations against the reference
    for (int i = 0; i < 1000; i++) rand_op(i < 200);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
